// File: rtl/deg_to_rad_reduce_pkg.sv
// Shared constants and state encoding for the degree-to-radian front end.
// Optional wrap counter is enabled with DEG2RAD_WRAP_CNT_EN.
package deg_to_rad_reduce_pkg;

    localparam int DEF_DEG_W   = 10;
    localparam int DEF_RAD_W   = 8;
    localparam int DEF_FRAC_W  = 7;
    localparam int DEF_K_PI180 = 286;
    localparam int REF_W       = 7;

    localparam int DEG_90  = 90;
    localparam int DEG_180 = 180;
    localparam int DEG_270 = 270;
    localparam int DEG_360 = 360;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRAP,
        S_QUAD,
        S_MULT,
        S_DONE
    } state_t;

    function automatic int rnd_const(input int frac_w);
        return 1 << (frac_w - 1);
    endfunction

endpackage

// File: rtl/deg_to_rad_reduce_if.sv
// Upstream/downstream handshake bundle for deg_to_rad_reduce.
// wrap_cnt_80 exists only with DEG2RAD_WRAP_CNT_EN.
interface deg_to_rad_reduce_if
    import deg_to_rad_reduce_pkg::*;
#(
    parameter int DEG_W = DEF_DEG_W,
    parameter int RAD_W = DEF_RAD_W
) ();

    logic [DEG_W-1:0] deg_in_80;
    logic             in_valid_80;
    logic             in_ready_80;
    logic [RAD_W-1:0] radian_80;
    logic [1:0]       quadrant_80;
    logic             cos_neg_80;
    logic             out_valid_80;
    logic             out_ready_80;
`ifdef DEG2RAD_WRAP_CNT_EN
    logic [7:0]       wrap_cnt_80;
`endif

    modport master (
        output deg_in_80,
        output in_valid_80,
        output out_ready_80,
        input  in_ready_80,
        input  radian_80,
        input  quadrant_80,
        input  cos_neg_80,
`ifdef DEG2RAD_WRAP_CNT_EN
        input  wrap_cnt_80,
`endif
        input  out_valid_80
    );

    modport slave (
        input  deg_in_80,
        input  in_valid_80,
        input  out_ready_80,
        output in_ready_80,
        output radian_80,
        output quadrant_80,
        output cos_neg_80,
`ifdef DEG2RAD_WRAP_CNT_EN
        output wrap_cnt_80,
`endif
        output out_valid_80
    );

endinterface

// File: rtl/deg_to_rad_reduce_kmul.sv
// Combinational ref*K with round-half-up, scaled down to Q1.7 radians.
// Shared by all builds (DEG2RAD_WRAP_CNT_EN has no effect here).
module deg_to_rad_reduce_kmul
    import deg_to_rad_reduce_pkg::*;
#(
    parameter int RAD_W   = DEF_RAD_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int K_PI180 = DEF_K_PI180
) (
    input  logic [REF_W-1:0] ref_deg,
    output logic [RAD_W-1:0] radian
);

    localparam int          RND = rnd_const(FRAC_W);
    localparam logic [15:0] K16 = 16'(K_PI180);
    localparam logic [15:0] R16 = 16'(RND);

    // 90*286+64 still fits in 16 bits, so no saturation is needed
    logic [15:0] prod;

    assign prod   = 16'(ref_deg) * K16 + R16;
    assign radian = RAD_W'(prod >> FRAC_W);

endmodule

// File: rtl/deg_to_rad_reduce.sv
// Wraps degrees mod 360, folds to quadrant 0 and converts to Q1.7 radians.
// Define DEG2RAD_WRAP_CNT_EN to add the saturating wrap_cnt_80 counter.
module deg_to_rad_reduce
    import deg_to_rad_reduce_pkg::*;
#(
    parameter int DEG_W   = DEF_DEG_W,
    parameter int RAD_W   = DEF_RAD_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int K_PI180 = DEF_K_PI180
) (
    input logic           clk_80,
    input logic           reset_80,
    deg_to_rad_reduce_if.slave bus
);

    localparam logic [DEG_W-1:0] D90  = DEG_W'(DEG_90);
    localparam logic [DEG_W-1:0] D180 = DEG_W'(DEG_180);
    localparam logic [DEG_W-1:0] D270 = DEG_W'(DEG_270);
    localparam logic [DEG_W-1:0] D360 = DEG_W'(DEG_360);

    state_t             state;
    logic [DEG_W-1:0]   acc;
    logic [REF_W-1:0]   ref_deg;
    logic [1:0]         quad_q;
    logic               neg_q;
    logic [RAD_W-1:0]   rad_c;

    assign bus.in_ready_80 = (state == S_IDLE);

    deg_to_rad_reduce_kmul #(
        .RAD_W   (RAD_W),
        .FRAC_W  (FRAC_W),
        .K_PI180 (K_PI180)
    ) u_kmul (
        .ref_deg (ref_deg),
        .radian  (rad_c)
    );

    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            state            <= S_IDLE;
            acc              <= '0;
            ref_deg          <= '0;
            quad_q           <= '0;
            neg_q            <= 1'b0;
            bus.radian_80    <= '0;
            bus.quadrant_80  <= '0;
            bus.cos_neg_80   <= 1'b0;
            bus.out_valid_80 <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid_80) begin
                        acc   <= bus.deg_in_80;
                        state <= S_WRAP;
                    end
                end
                S_WRAP: begin
                    if (acc >= D360) acc <= acc - D360;
                    else state <= S_QUAD;
                end
                S_QUAD: begin
                    unique case (1'b1)
                        (acc < D90): begin
                            quad_q  <= 2'd0;
                            ref_deg <= REF_W'(acc);
                            neg_q   <= 1'b0;
                        end
                        (acc >= D90 && acc < D180): begin
                            quad_q  <= 2'd1;
                            ref_deg <= REF_W'(D180 - acc);
                            neg_q   <= 1'b1;
                        end
                        (acc >= D180 && acc < D270): begin
                            quad_q  <= 2'd2;
                            ref_deg <= REF_W'(acc - D180);
                            neg_q   <= 1'b1;
                        end
                        (acc >= D270): begin
                            quad_q  <= 2'd3;
                            ref_deg <= REF_W'(D360 - acc);
                            neg_q   <= 1'b0;
                        end
                    endcase
                    state <= S_MULT;
                end
                S_MULT: begin
                    bus.radian_80    <= rad_c;
                    bus.quadrant_80  <= quad_q;
                    bus.cos_neg_80   <= neg_q;
                    bus.out_valid_80 <= 1'b1;
                    state            <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready_80) begin
                        bus.out_valid_80 <= 1'b0;
                        state            <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DEG2RAD_WRAP_CNT_EN
    logic [7:0] wrap_cnt;

    // counts on the accepting edge, sticks at 255
    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            wrap_cnt <= '0;
        end else if (bus.in_ready_80 && bus.in_valid_80 &&
                     bus.deg_in_80 >= D360 && wrap_cnt != 8'hFF) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end

    assign bus.wrap_cnt_80 = wrap_cnt;
`endif

endmodule

// File: tb/tb_deg_to_rad_reduce.sv
// Scoreboard bench for deg_to_rad_reduce with a plain-arithmetic model.
// Also checks wrap_cnt_80 when built with DEG2RAD_WRAP_CNT_EN.
module tb_deg_to_rad_reduce;

    typedef struct {
        int rad;
        int quad;
        int neg;
        int lat;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wc_model = 0;
    logic rand_ready = 1'b0;
    logic force_ready = 1'b1;
    logic rnd_rdy = 1'b1;
    logic prev_ov = 1'b0;
    exp_t q[$];

    deg_to_rad_reduce_if bus ();

    deg_to_rad_reduce dut (
        .clk_80   (clk),
        .reset_80 (rst),
        .bus      (bus)
    );

    assign bus.out_ready_80 = rand_ready ? rnd_rdy : force_ready;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    // Monitor: compares every cycle the DUT presents a result
    always @(negedge clk) begin
        if (!rst && bus.out_valid_80) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got radian 0x%0h expected none",
                         bus.radian_80);
            end else begin
                chk("radian", int'(bus.radian_80), q[0].rad);
                chk("quadrant", int'(bus.quadrant_80), q[0].quad);
                chk("cos_neg", int'(bus.cos_neg_80), q[0].neg);
                if (!prev_ov)
                    chk("latency", cyc - q[0].acc_cyc, q[0].lat);
                if (bus.out_ready_80) q.delete(0);
            end
        end
        prev_ov = !rst && bus.out_valid_80;
    end

    task automatic send(input int d);
        exp_t e;
        int   w;
        int   r;
        bit   got;
        got = 0;
        bus.deg_in_80   = 10'(d);
        bus.in_valid_80 = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready_80) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid_80 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        w = d % 360;
        e.quad = w / 90;
        case (e.quad)
            0: r = w;
            1: r = 180 - w;
            2: r = w - 180;
            default: r = 360 - w;
        endcase
        e.rad = (r * 286 + 64) / 128;
        e.neg = (e.quad == 1 || e.quad == 2) ? 1 : 0;
        e.lat = d / 360 + 3;
        e.acc_cyc = cyc;
        q.push_back(e);
        if (d >= 360 && wc_model < 255) wc_model++;
        bus.in_valid_80 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (q.size() != 0); i++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        #1;
    endtask

    task automatic chk_wc();
`ifdef DEG2RAD_WRAP_CNT_EN
        chk("wrap_cnt", int'(bus.wrap_cnt_80), wc_model);
`endif
    endtask

    int dir_list[12] = '{10, 90, 200, 359, 700, 1023,
                         0, 360, 180, 270, 719, 1000};

    initial begin
        bit seen;
        bus.deg_in_80   = '0;
        bus.in_valid_80 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(bus.out_valid_80), 0);
        chk("rst_radian", int'(bus.radian_80), 0);
        chk("rst_quadrant", int'(bus.quadrant_80), 0);
        chk("rst_cos_neg", int'(bus.cos_neg_80), 0);
        chk("rst_in_ready", int'(bus.in_ready_80), 1);
        chk_wc();

        foreach (dir_list[i]) send(dir_list[i]);
        drain();

        rand_ready = 1'b1;
        repeat (60) send(int'($urandom_range(0, 1023)));
        drain();
        rand_ready = 1'b0;
        chk_wc();

        // Backpressure: result held while downstream stalls
        force_ready = 1'b0;
        send(30);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid_80) seen = 1;
        end
        chk("bp_out_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.deg_in_80   = 10'(500);
            bus.in_valid_80 = 1'b1;
            chk("bp_in_ready", int'(bus.in_ready_80), 0);
            chk("bp_out_valid", int'(bus.out_valid_80), 1);
        end
        bus.in_valid_80 = 1'b0;
        force_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", int'(bus.in_ready_80), 1);
        chk("bp_release_valid", int'(bus.out_valid_80), 0);
        drain();

        // Reset while 1000 is still wrapping
        send(1000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        wc_model = 0;
        chk("mid_rst_out_valid", int'(bus.out_valid_80), 0);
        chk("mid_rst_radian", int'(bus.radian_80), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready_80), 1);
        chk_wc();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_output", int'(bus.out_valid_80), 0);

`ifdef DEG2RAD_WRAP_CNT_EN
        repeat (10) send(400);
        drain();
        chk_wc();
        repeat (290) send(400);
        drain();
        chk_wc();
        chk("wrap_cnt_sat", int'(bus.wrap_cnt_80), 255);
        repeat (5) send(int'($urandom_range(0, 359)));
        drain();
        chk_wc();
`endif

        send(90);
        send(1023);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
